v_query_rsp_q: RTL and testbench
================================

Name: v_query_rsp_q

Overview:
- Downstream neighbour of the list query pipe. Captures the S1 query result (key, volume, error, listsize) one cycle after each issued lookup.
- Tags each result with a sequence number and buffers it in a small FIFO. Results are presented to the consumer over a valid/ready interface.
- Gives the upstream issuer a credit-style ready, so a query already in flight always has a guaranteed FIFO slot. The query pipe itself has no backpressure.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >= 2).
- TAG_W, 4, width of the per-response sequence tag (wraps modulo 2^TAG_W).
- ERRCNT_W, 8, width of the saturating error-response counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_lut_vld  in  1  lookup issued to query pipe this cycle (S0).
- o_lut_rdy  out  1  issuer may assert i_lut_vld this cycle.
- i_lut_key  in  $bits(v_pkg::key_t)  S1 key from query pipe.
- i_lut_size  in  $bits(v_pkg::volume_t)  S1 volume from query pipe.
- i_lut_error  in  1  S1 error from query pipe.
- i_lut_listsize  in  $bits(v_pkg::listsize_t)  S1 listsize from query pipe.
- o_rsp_vld  out  1  head response valid.
- i_rsp_rdy  in  1  consumer accepts head response.
- o_rsp_key  out  $bits(v_pkg::key_t)  head key.
- o_rsp_size  out  $bits(v_pkg::volume_t)  head volume.
- o_rsp_error  out  1  head error flag.
- o_rsp_listsize  out  $bits(v_pkg::listsize_t)  head listsize.
- o_rsp_tag  out  TAG_W  head sequence tag.
- o_drop  out  1  pulse: i_lut_vld seen while o_lut_rdy low.
- o_err_cnt  out  ERRCNT_W  saturating count of error responses pushed.

Behaviour:
- Issue: accept = i_lut_vld & o_lut_rdy. Register s1_vld_r <= accept.
- Illegal issue: i_lut_vld & !o_lut_rdy is not captured. o_drop = 1 that cycle (combinational), and s1_vld_r = 0 next cycle.
- Capture:
  - When s1_vld_r = 1, push {i_lut_key, i_lut_size, i_lut_error, i_lut_listsize, tag_r} at the wr_ptr entry.
  - wr_ptr increments (wraps at DEPTH). tag_r increments (wraps at 2^TAG_W).
  - Capture is unconditional: credit guarantees space.
- Latency:
  - Issue in cycle T; data is valid on i_lut_* in T+1; entry is written at the end of T+1.
  - o_rsp_vld is asserted in T+2 at the earliest. No bypass path.
- Pop: pop = o_rsp_vld & i_rsp_rdy. rd_ptr increments with wrap.
- o_rsp_vld = (cnt != 0). o_rsp_* are driven from the rd_ptr entry and held stable while o_rsp_vld & !i_rsp_rdy.
- Occupancy cnt (width clog2(DEPTH)+1):
  - push only: +1. pop only: -1. Simultaneous push and pop: unchanged.
- Credit: o_lut_rdy = (cnt + s1_vld_r) < DEPTH.
  - Conservative: a same-cycle pop does not raise rdy. rdy is combinational from registers only.
- Full: cnt == DEPTH implies o_lut_rdy = 0.
- Empty: cnt == 0 implies o_rsp_vld = 0, and i_rsp_rdy is ignored.
- o_err_cnt increments on every push with i_lut_error = 1. It saturates at all-ones and never wraps.
- Reset:
  - cnt, rd_ptr, wr_ptr, s1_vld_r, tag_r and o_err_cnt clear to 0.
  - Consequently o_rsp_vld = 0, o_lut_rdy = 1, o_drop = 0 (when i_lut_vld = 0).
  - Storage array is not reset.
  - A query in flight at reset is discarded: s1_vld_r is cleared, so no push occurs in the following cycle.
- Assertions:
  - cnt <= DEPTH.
  - No push when cnt == DEPTH and pop == 0.
  - o_rsp_* stable while stalled.

Test Plan:
- Single query: reset, i_lut_vld at T; at T+1 drive key='h5A, size=7, error=0, listsize=3 -> o_rsp_vld rises at T+2 with those values and tag=0; i_rsp_rdy=1 at T+2 -> o_rsp_vld=0 at T+3.
- Fill with consumer stalled (DEPTH=4): issue every cycle while o_lut_rdy, i_rsp_rdy=0 -> exactly 4 accepted, o_lut_rdy=0 from the cycle after the 4th issue, tags 0,1,2,3 in order, head stable.
- Illegal issue: with o_lut_rdy=0, pulse i_lut_vld -> o_drop=1 that cycle, no push, cnt stays 4.
- Simultaneous push/pop: steady stream with i_rsp_rdy=1 -> cnt constant at 1, one response per cycle, tags wrap 15 -> 0 after 16 responses.
- Error counter (ERRCNT_W=2): push 5 responses with error=1 -> o_err_cnt = 1, 2, 3, 3, 3.
- Reset mid-flight: issue at T, assert rst at T+1 -> no push at T+1; after reset o_rsp_vld=0, o_lut_rdy=1, next response has tag=0.

Source files
------------

// File: rtl/v_query_rsp_q.sv
// Response queue behind the list query pipe: captures each S1 lookup result,
// tags it with a sequence number, buffers it, and hands out issue credit so a
// lookup in flight always has a free slot waiting for it.

package v_pkg;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  volume_t;
  typedef logic [3:0]  listsize_t;
endpackage

module v_query_rsp_q #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_lut_vld,
  output logic                o_lut_rdy,
  input  v_pkg::key_t         i_lut_key,
  input  v_pkg::volume_t      i_lut_size,
  input  logic                i_lut_error,
  input  v_pkg::listsize_t    i_lut_listsize,
  output logic                o_rsp_vld,
  input  logic                i_rsp_rdy,
  output v_pkg::key_t         o_rsp_key,
  output v_pkg::volume_t      o_rsp_size,
  output logic                o_rsp_error,
  output v_pkg::listsize_t    o_rsp_listsize,
  output logic [TAG_W-1:0]    o_rsp_tag,
  output logic                o_drop,
  output logic [ERRCNT_W-1:0] o_err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    v_pkg::key_t      key;
    v_pkg::volume_t   size;
    logic             error;
    v_pkg::listsize_t listsize;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              wr_entry;
  entry_t              head;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                s1_vld_q, s1_vld_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                accept;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      credit_sum;

  assign head = mem_q[rd_ptr_q];

  // Credit, handshake decode and next-state for pointers, occupancy, tag and error count.
  always_comb begin
    // In-flight lookup counts against capacity; a same-cycle pop is deliberately ignored.
    credit_sum = {1'b0, cnt_q} + {{CNT_W{1'b0}}, s1_vld_q};
    o_lut_rdy  = credit_sum < (CNT_W + 1)'(DEPTH);
    accept     = i_lut_vld & o_lut_rdy;
    o_drop     = i_lut_vld & ~o_lut_rdy;
    o_rsp_vld  = (cnt_q != '0);
    push       = s1_vld_q;
    pop        = o_rsp_vld & i_rsp_rdy;

    wr_entry.key      = i_lut_key;
    wr_entry.size     = i_lut_size;
    wr_entry.error    = i_lut_error;
    wr_entry.listsize = i_lut_listsize;
    wr_entry.tag      = tag_q;

    s1_vld_d  = accept;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    err_cnt_d = err_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      tag_d    = tag_q + 1'b1;
      if (i_lut_error && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    o_rsp_key      = head.key;
    o_rsp_size     = head.size;
    o_rsp_error    = head.error;
    o_rsp_listsize = head.listsize;
    o_rsp_tag      = head.tag;
    o_err_cnt      = err_cnt_q;
  end

  // Control registers; clearing s1_vld_q drops any lookup in flight at reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      tag_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      tag_q     <= tag_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Entry storage, written unconditionally on capture and never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_W'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_q == CNT_W'(DEPTH)) && !pop));

  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (o_rsp_vld && !i_rsp_rdy) |=> $stable(head));

endmodule

// File: tb/tb_v_query_rsp_q.sv
// Bench for v_query_rsp_q: reference model of credit/occupancy plus a queue of
// expected responses filled as capture data is driven and drained on pops.

module tb_v_query_rsp_q;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_lut_vld;
  logic             o_lut_rdy;
  v_pkg::key_t      i_lut_key;
  v_pkg::volume_t   i_lut_size;
  logic             i_lut_error;
  v_pkg::listsize_t i_lut_listsize;
  logic             o_rsp_vld;
  logic             i_rsp_rdy;
  v_pkg::key_t      o_rsp_key;
  v_pkg::volume_t   o_rsp_size;
  logic             o_rsp_error;
  v_pkg::listsize_t o_rsp_listsize;
  logic [3:0]       o_rsp_tag;
  logic             o_drop;
  logic [1:0]       o_err_cnt;

  always #5 clk = ~clk;

  v_query_rsp_q #(.DEPTH(4), .TAG_W(4), .ERRCNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_lut_vld      (i_lut_vld),
    .o_lut_rdy      (o_lut_rdy),
    .i_lut_key      (i_lut_key),
    .i_lut_size     (i_lut_size),
    .i_lut_error    (i_lut_error),
    .i_lut_listsize (i_lut_listsize),
    .o_rsp_vld      (o_rsp_vld),
    .i_rsp_rdy      (i_rsp_rdy),
    .o_rsp_key      (o_rsp_key),
    .o_rsp_size     (o_rsp_size),
    .o_rsp_error    (o_rsp_error),
    .o_rsp_listsize (o_rsp_listsize),
    .o_rsp_tag      (o_rsp_tag),
    .o_drop         (o_drop),
    .o_err_cnt      (o_err_cnt)
  );

  typedef struct {
    v_pkg::key_t      key;
    v_pkg::volume_t   size;
    logic             err;
    v_pkg::listsize_t ls;
    logic [3:0]       tag;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  int mdl_cnt;
  bit mdl_s1;
  int mdl_tag;
  int mdl_err;

  v_pkg::key_t      nk;
  v_pkg::volume_t   nsz;
  logic             ne;
  v_pkg::listsize_t nls;
  bit               rand_data;

  function automatic bit mdl_rdy();
    return (mdl_cnt + int'(mdl_s1)) < 4;
  endfunction

  function automatic logic [32:0] head_exp();
    exp_t e;
    e = sb[0];
    return {e.key, e.size, e.err, e.ls, e.tag};
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    i_lut_vld      = 1'b0;
    i_rsp_rdy      = 1'b0;
    i_lut_key      = '0;
    i_lut_size     = '0;
    i_lut_error    = 1'b0;
    i_lut_listsize = '0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    mdl_cnt = 0;
    mdl_s1  = 1'b0;
    mdl_tag = 0;
    mdl_err = 0;
    sb.delete();
    #1;
  endtask

  // Drive one cycle of inputs; capture data is only meaningful when the model has a lookup in flight.
  task automatic set_in(input bit vld, input bit rrdy);
    exp_t e;
    i_lut_vld = vld;
    i_rsp_rdy = rrdy;
    if (mdl_s1) begin
      if (rand_data) begin
        nk  = 16'($urandom);
        nsz = 8'($urandom);
        ne  = 1'($urandom_range(0, 1));
        nls = 4'($urandom);
      end
      i_lut_key      = nk;
      i_lut_size     = nsz;
      i_lut_error    = ne;
      i_lut_listsize = nls;
      e.key = nk; e.size = nsz; e.err = ne; e.ls = nls; e.tag = 4'(mdl_tag);
      sb.push_back(e);
    end else begin
      i_lut_key      = 16'($urandom);
      i_lut_size     = 8'($urandom);
      i_lut_error    = 1'($urandom_range(0, 1));
      i_lut_listsize = 4'($urandom);
    end
    #1;
  endtask

  // Advance the reference model across the coming clock edge.
  task automatic adv();
    bit rdy;
    bit pop;
    rdy = mdl_rdy();
    pop = (mdl_cnt != 0) && i_rsp_rdy;
    if (pop) void'(sb.pop_front());
    if (mdl_s1) begin
      mdl_tag = (mdl_tag + 1) % 16;
      if (i_lut_error && mdl_err < 3) mdl_err++;
    end
    mdl_cnt = mdl_cnt + int'(mdl_s1) - int'(pop);
    mdl_s1  = i_lut_vld && rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    i_lut_vld = 1'b0;
    #1;
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", o_rsp_vld); end
    n_tests++;
    if (o_lut_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", o_lut_rdy); end
    n_tests++;
    if (o_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", o_drop); end
    n_tests++;
    if (o_err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", o_err_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    rand_data = 1'b0;
    nk = 16'h005A; nsz = 8'd7; ne = 1'b0; nls = 4'd3;
    set_in(1'b1, 1'b0);
    n_tests++;
    if (o_lut_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy_T: got %b want 1", o_lut_rdy); end
    adv();
    set_in(1'b0, 1'b0);
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", o_rsp_vld); end
    adv();
    set_in(1'b0, 1'b1);
    n_tests++;
    if (o_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld_T2: got %b want 1", o_rsp_vld); end
    n_tests++;
    if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize, o_rsp_tag} !== {16'h005A, 8'd7, 1'b0, 4'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL single_data: got key=%h size=%0d err=%b ls=%0d tag=%0d want key=005a size=7 err=0 ls=3 tag=0",
               o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize, o_rsp_tag);
    end
    adv();
    set_in(1'b0, 1'b0);
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld_T3: got %b want 0", o_rsp_vld); end
    adv();
  endtask

  task automatic test_fill_and_drop();
    int accepted;
    int responses;
    do_reset();
    rand_data = 1'b1;
    accepted  = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(o_lut_rdy, 1'b0);
      n_tests++;
      if (o_lut_rdy !== mdl_rdy()) begin n_fail++; $display("FAIL fill_rdy[%0d]: got %b want %b", i, o_lut_rdy, mdl_rdy()); end
      n_tests++;
      if (o_rsp_vld !== (mdl_cnt != 0)) begin n_fail++; $display("FAIL fill_vld[%0d]: got %b want %b", i, o_rsp_vld, mdl_cnt != 0); end
      if (mdl_cnt != 0) begin
        n_tests++;
        if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize, o_rsp_tag} !== head_exp()) begin
          n_fail++; $display("FAIL fill_head_stable[%0d]: got tag=%0d key=%h want %h", i, o_rsp_tag, o_rsp_key, head_exp());
        end
      end
      if (i_lut_vld) accepted++;
      adv();
    end
    n_tests++;
    if (accepted != 4) begin n_fail++; $display("FAIL fill_accepted: got %0d want 4", accepted); end

    set_in(1'b1, 1'b0);
    n_tests++;
    if (o_drop !== 1'b1) begin n_fail++; $display("FAIL illegal_drop: got %b want 1", o_drop); end
    n_tests++;
    if (o_lut_rdy !== 1'b0) begin n_fail++; $display("FAIL illegal_rdy: got %b want 0", o_lut_rdy); end
    adv();
    set_in(1'b0, 1'b0);
    n_tests++;
    if (o_drop !== 1'b0) begin n_fail++; $display("FAIL illegal_drop_clear: got %b want 0", o_drop); end
    n_tests++;
    if (o_lut_rdy !== 1'b0) begin n_fail++; $display("FAIL illegal_still_full: got %b want 0", o_lut_rdy); end
    adv();

    responses = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1);
      n_tests++;
      if (o_rsp_vld !== (mdl_cnt != 0)) begin n_fail++; $display("FAIL drain_vld[%0d]: got %b want %b", i, o_rsp_vld, mdl_cnt != 0); end
      if (mdl_cnt != 0) begin
        n_tests++;
        if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize, o_rsp_tag} !== head_exp()) begin
          n_fail++; $display("FAIL drain_order[%0d]: got tag=%0d key=%h want %h", i, o_rsp_tag, o_rsp_key, head_exp());
        end
      end
      if (o_rsp_vld === 1'b1) responses++;
      adv();
    end
    n_tests++;
    if (responses != 4) begin n_fail++; $display("FAIL drain_count: got %0d want 4", responses); end
  endtask

  task automatic test_back_to_back();
    int  prev_tag;
    bit  wrapped;
    int  responses;
    do_reset();
    rand_data = 1'b1;
    prev_tag  = -1;
    wrapped   = 1'b0;
    responses = 0;
    for (int i = 0; i < 22; i++) begin
      set_in(i < 20, 1'b1);
      if (i >= 2 && i < 21) begin
        n_tests++;
        if (o_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL stream_vld[%0d]: got %b want 1", i, o_rsp_vld); end
      end
      n_tests++;
      if (o_lut_rdy !== mdl_rdy()) begin n_fail++; $display("FAIL stream_rdy[%0d]: got %b want %b", i, o_lut_rdy, mdl_rdy()); end
      if (mdl_cnt != 0) begin
        n_tests++;
        if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize, o_rsp_tag} !== head_exp()) begin
          n_fail++; $display("FAIL stream_data[%0d]: got tag=%0d key=%h want %h", i, o_rsp_tag, o_rsp_key, head_exp());
        end
      end
      if (o_rsp_vld === 1'b1) begin
        responses++;
        if (prev_tag == 15 && o_rsp_tag == 4'd0) wrapped = 1'b1;
        prev_tag = int'(o_rsp_tag);
      end
      adv();
    end
    n_tests++;
    if (responses != 20) begin n_fail++; $display("FAIL stream_count: got %0d want 20", responses); end
    n_tests++;
    if (wrapped !== 1'b1) begin n_fail++; $display("FAIL stream_tag_wrap: got %b want 1", wrapped); end
    set_in(1'b0, 1'b0);
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b want 0", o_rsp_vld); end
    adv();
  endtask

  task automatic test_err_cnt();
    do_reset();
    rand_data = 1'b0;
    nk = 16'h1234; nsz = 8'd1; ne = 1'b1; nls = 4'd2;
    for (int i = 0; i < 8; i++) begin
      set_in(i < 5, 1'b1);
      n_tests++;
      if (o_err_cnt !== 2'(mdl_err)) begin n_fail++; $display("FAIL errcnt[%0d]: got %0d want %0d", i, o_err_cnt, mdl_err); end
      adv();
    end
    n_tests++;
    if (o_err_cnt !== 2'd3) begin n_fail++; $display("FAIL errcnt_saturate: got %0d want 3", o_err_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_data = 1'b0;
    nk = 16'hBEEF; nsz = 8'd9; ne = 1'b1; nls = 4'd5;
    set_in(1'b1, 1'b0);
    adv();
    rst            = 1'b1;
    i_lut_vld      = 1'b0;
    i_lut_key      = nk;
    i_lut_size     = nsz;
    i_lut_error    = ne;
    i_lut_listsize = nls;
    @(negedge clk);
    rst     = 1'b0;
    mdl_cnt = 0;
    mdl_s1  = 1'b0;
    mdl_tag = 0;
    mdl_err = 0;
    sb.delete();
    #1;
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld: got %b want 0", o_rsp_vld); end
    n_tests++;
    if (o_lut_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy: got %b want 1", o_lut_rdy); end
    n_tests++;
    if (o_err_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_errcnt: got %0d want 0", o_err_cnt); end
    set_in(1'b0, 1'b0);
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_push: got %b want 0", o_rsp_vld); end
    adv();
    nk = 16'h0033; nsz = 8'd4; ne = 1'b0; nls = 4'd1;
    set_in(1'b1, 1'b0);
    adv();
    set_in(1'b0, 1'b0);
    adv();
    set_in(1'b0, 1'b1);
    n_tests++;
    if (o_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_vld: got %b want 1", o_rsp_vld); end
    n_tests++;
    if ({o_rsp_key, o_rsp_tag} !== {16'h0033, 4'd0}) begin
      n_fail++; $display("FAIL rstmid_next_tag: got key=%h tag=%0d want key=0033 tag=0", o_rsp_key, o_rsp_tag);
    end
    adv();
    set_in(1'b0, 1'b0);
    n_tests++;
    if (o_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_single: got %b want 0", o_rsp_vld); end
    adv();
  endtask

  initial begin
    rand_data = 1'b0;
    nk = '0; nsz = '0; ne = 1'b0; nls = '0;
    test_reset();
    test_single();
    test_fill_and_drop();
    test_back_to_back();
    test_err_cnt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
